// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The controller drives through the master modport; the datapath (or a bench) uses slave.
interface multicycle_controller_if #(
   parameter int RETIRE_W = 32
) ();
   logic [5:0]          op;
   logic [5:0]          funct;
   logic                zero;
   logic                mem_ready;
   logic                memreq;
   logic                memwrite;
   logic                iord;
   logic                irwrite;
   logic                pcen;
   logic [1:0]          pcsrc;
   logic                alusrca;
   logic [1:0]          alusrcb;
   logic                ori;
   logic                regdst;
   logic                memtoreg;
   logic                regwrite;
   logic [2:0]          alucontrol;
   logic                illegal;
   logic [3:0]          state;
   logic [RETIRE_W-1:0] instret;

   // Memory handshake: memreq stays high for the whole access; the access completes on the
   // rising edge where memreq and mem_ready are both high. mem_ready is ignored otherwise.
   modport master (
      input  op, funct, zero, mem_ready,
      output memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb, ori,
             regdst, memtoreg, regwrite, alucontrol, illegal, state, instret
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  memreq, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb, ori,
             regdst, memtoreg, regwrite, alucontrol, illegal, state, instret
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multicycle MIPS datapath: per-state selects and strobes,
// memory stalls, branch PC enable, illegal-encoding pulse and retired-instruction count.
module multicycle_controller #(
   parameter int RETIRE_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   multicycle_controller_if.master  bus
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQ     = 4'd8,
      S_BNE     = 4'd9,
      S_ADDIEX  = 4'd10,
      S_IMMWB   = 4'd11,
      S_ORIEX   = 4'd12,
      S_JUMP    = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t              r_state;
   state_t              w_next_state;
   logic [RETIRE_W-1:0] r_instret;

   logic                w_op_ok;
   logic                w_funct_ok;
   logic [2:0]          w_funct_alu;
   logic                w_retire;

   logic                w_memreq;
   logic                w_memwrite;
   logic                w_iord;
   logic                w_irwrite;
   logic                w_pcwrite;
   logic                w_branch;
   logic                w_bne;
   logic [1:0]          w_pcsrc;
   logic                w_alusrca;
   logic [1:0]          w_alusrcb;
   logic                w_ori;
   logic                w_regdst;
   logic                w_memtoreg;
   logic                w_regwrite;
   logic [2:0]          w_alucontrol;
   logic                w_illegal;

   always_comb begin
      w_op_ok = 1'b0;
      case (bus.op)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J: w_op_ok = 1'b1;
         default:                                                      w_op_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_funct_ok  = 1'b1;
      w_funct_alu = ALU_ADD;
      case (bus.funct)
         6'b100000: w_funct_alu = ALU_ADD;
         6'b100010: w_funct_alu = ALU_SUB;
         6'b100100: w_funct_alu = ALU_AND;
         6'b100101: w_funct_alu = ALU_OR;
         6'b101010: w_funct_alu = ALU_SLT;
         default: begin
            w_funct_ok  = 1'b0;
            w_funct_alu = ALU_ADD;
         end
      endcase
   end

   // State register; reset takes effect immediately, not at the next edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = S_FETCH;
      case (r_state)
         S_FETCH:   w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: w_next_state = S_MEMADR;
               OP_RTYPE:     w_next_state = S_RTYPEEX;
               OP_BEQ:       w_next_state = S_BEQ;
               OP_BNE:       w_next_state = S_BNE;
               OP_ADDI:      w_next_state = S_ADDIEX;
               OP_ORI:       w_next_state = S_ORIEX;
               OP_J:         w_next_state = S_JUMP;
               default:      w_next_state = S_FETCH;
            endcase
         end
         S_MEMADR:  w_next_state = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   w_next_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:   w_next_state = S_FETCH;
         S_MEMWR:   w_next_state = bus.mem_ready ? S_FETCH : S_MEMWR;
         S_RTYPEEX: w_next_state = w_funct_ok ? S_RTYPEWB : S_FETCH;
         S_RTYPEWB: w_next_state = S_FETCH;
         S_BEQ:     w_next_state = S_FETCH;
         S_BNE:     w_next_state = S_FETCH;
         S_ADDIEX:  w_next_state = S_IMMWB;
         S_ORIEX:   w_next_state = S_IMMWB;
         S_IMMWB:   w_next_state = S_FETCH;
         S_JUMP:    w_next_state = S_FETCH;
         default:   w_next_state = S_FETCH;
      endcase
   end

   always_comb begin
      w_memreq     = 1'b0;
      w_memwrite   = 1'b0;
      w_iord       = 1'b0;
      w_irwrite    = 1'b0;
      w_pcwrite    = 1'b0;
      w_branch     = 1'b0;
      w_bne        = 1'b0;
      w_pcsrc      = 2'b00;
      w_alusrca    = 1'b0;
      w_alusrcb    = 2'b00;
      w_ori        = 1'b0;
      w_regdst     = 1'b0;
      w_memtoreg   = 1'b0;
      w_regwrite   = 1'b0;
      w_alucontrol = ALU_ADD;
      w_illegal    = 1'b0;
      case (r_state)
         S_FETCH: begin
            // PC+4 is written back in the same cycle the instruction register loads.
            w_memreq  = 1'b1;
            w_alusrcb = 2'b01;
            w_irwrite = bus.mem_ready;
            w_pcwrite = bus.mem_ready;
         end
         S_DECODE: begin
            w_alusrcb = 2'b11;
            w_illegal = ~w_op_ok;
         end
         S_MEMADR: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
         end
         S_MEMRD: begin
            w_memreq = 1'b1;
            w_iord   = 1'b1;
         end
         S_MEMWB: begin
            w_regwrite = 1'b1;
            w_memtoreg = 1'b1;
         end
         S_MEMWR: begin
            w_memreq   = 1'b1;
            w_memwrite = 1'b1;
            w_iord     = 1'b1;
         end
         S_RTYPEEX: begin
            w_alusrca    = 1'b1;
            w_alucontrol = w_funct_alu;
            w_illegal    = ~w_funct_ok;
         end
         S_RTYPEWB: begin
            w_regwrite = 1'b1;
            w_regdst   = 1'b1;
         end
         S_BEQ: begin
            w_alusrca    = 1'b1;
            w_alucontrol = ALU_SUB;
            w_pcsrc      = 2'b01;
            w_branch     = 1'b1;
         end
         S_BNE: begin
            w_alusrca    = 1'b1;
            w_alucontrol = ALU_SUB;
            w_pcsrc      = 2'b01;
            w_bne        = 1'b1;
         end
         S_ADDIEX: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
         end
         S_ORIEX: begin
            w_alusrca    = 1'b1;
            w_alusrcb    = 2'b10;
            w_alucontrol = ALU_OR;
            w_ori        = 1'b1;
         end
         S_IMMWB: begin
            w_regwrite = 1'b1;
         end
         S_JUMP: begin
            w_pcsrc   = 2'b10;
            w_pcwrite = 1'b1;
         end
         default: begin
            w_alucontrol = ALU_ADD;
         end
      endcase
   end

   always_comb begin
      w_retire = 1'b0;
      case (r_state)
         S_MEMWB, S_RTYPEWB, S_IMMWB, S_BEQ, S_BNE, S_JUMP: w_retire = 1'b1;
         S_MEMWR:                                         w_retire = bus.mem_ready;
         default:                                         w_retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_instret <= '0;
      end else if (w_retire) begin
         r_instret <= r_instret + 1'b1;
      end
   end

   // Side-effecting strobes are masked while reset is held so nothing fires during reset.
   assign bus.memreq     = w_memreq   & reset;
   assign bus.memwrite   = w_memwrite & reset;
   assign bus.irwrite    = w_irwrite  & reset;
   assign bus.pcen       = (w_pcwrite | (w_branch & bus.zero) | (w_bne & ~bus.zero)) & reset;
   assign bus.regwrite   = w_regwrite & reset;
   assign bus.illegal    = w_illegal  & reset;
   assign bus.iord       = w_iord;
   assign bus.pcsrc      = w_pcsrc;
   assign bus.alusrca    = w_alusrca;
   assign bus.alusrcb    = w_alusrcb;
   assign bus.ori        = w_ori;
   assign bus.regdst     = w_regdst;
   assign bus.memtoreg   = w_memtoreg;
   assign bus.alucontrol = w_alucontrol;
   assign bus.state      = r_state;
   assign bus.instret    = r_instret;

endmodule
